write_buffer: RTL

Write-through drain queue between the direct-mapped cache and main memory. Every cache write (17-bit word address, 32-bit data) is pushed here instead of updating memory in the same cycle. Entries drain to memory in FIFO order over a req/ack handshake. An optional forwarding port lets the cache's refill path see stores that are still queued.

---
 rtl/write_buffer_pkg.sv | 20 ++
 rtl/wb_fwd_match.sv | 38 +++
 rtl/write_buffer.sv | 119 +++++++++++
 3 files changed

// File: rtl/write_buffer_pkg.sv
// Shared cache definitions used by the write buffer: address split, entry layout and drain FSM states.
package write_buffer_pkg;

   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 32;
   localparam int TAG_W    = 3;
   localparam int INDEX_W  = 10;
   localparam int OFFSET_W = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      WB_IDLE,
      WB_ISSUE
   } wb_state_e;

endpackage

// File: rtl/wb_fwd_match.sv
// Store-to-load forwarding lookup: compares a lookup address against every queued entry
// and returns the data of the youngest match (the one closest to the tail).
module wb_fwd_match #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic [ADDR_W-1:0]          lk_addr_i,
   input  logic [ADDR_W-1:0]          addr_i [DEPTH],
   input  logic [DATA_W-1:0]          data_i [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   head_i,
   input  logic [$clog2(DEPTH):0]     count_i,
   output logic                       hit_o,
   output logic [DATA_W-1:0]          data_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] idx;
   logic [DEPTH-1:0] match;

   // Walk entries oldest to youngest so the last hit seen wins.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      match  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx      = head_i + PTR_W'(k);
         match[k] = (CNT_W'(k) < count_i) && (addr_i[idx] == lk_addr_i);
         if (match[k]) begin
            hit_o  = 1'b1;
            data_o = data_i[idx];
         end
      end
   end

endmodule

// File: rtl/write_buffer.sv
// Write-through drain queue between the cache and main memory, drained in FIFO order over req/ack.
// Optional store forwarding is built when WRITE_BUFFER_FWD_EN is defined.
module write_buffer #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic              drop,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic              mem_ack,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              lk_hit,
   output logic [DATA_W-1:0] lk_data
);
   import write_buffer_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_state_e         state_q, state_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic              push;
   logic              pop;

   // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign drop  = wr_en && full;
   assign push  = wr_en && !full;
   assign pop   = (state_q == WB_ISSUE) && mem_ack;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (count_q != '0) state_d = WB_ISSUE;
         end
         WB_ISSUE: begin
            mem_req = 1'b1;
            if (pop && (count_d == '0)) state_d = WB_IDLE;
         end
         default: state_d = WB_IDLE;
      endcase
   end

   assign mem_addr = mem_req ? addr_q[head_q] : '0;
   assign mem_data = mem_req ? data_q[head_q] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WB_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage carries no reset; validity is defined purely by head and count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= wr_addr;
         data_q[tail_q] <= wr_data;
      end
   end

`ifdef WRITE_BUFFER_FWD_EN
   wb_fwd_match #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fwd_match (
      .lk_addr_i (lk_addr),
      .addr_i    (addr_q),
      .data_i    (data_q),
      .head_i    (head_q),
      .count_i   (count_q),
      .hit_o     (lk_hit),
      .data_o    (lk_data)
   );
`else
   logic unused_lk_addr;
   assign unused_lk_addr = ^lk_addr;
   assign lk_hit  = 1'b0;
   assign lk_data = '0;
`endif

endmodule
